// File: rtl/lcd_port_arbiter.sv
// Arbitrates the character-LCD write port between buffered PS2 keyboard bytes and CPU writes.
// Define LCD_ARB_CPU_PRIO_EN for fixed CPU priority; the default build is round-robin.
module lcd_port_arbiter #(
  parameter int unsigned PS2_FIFO_DEPTH = 4,
  parameter int unsigned HOLD_CYCLES    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_key_pressed,
  input  logic [7:0]  ps2_key_data,
  input  logic        cpu_write_en,
  input  logic [31:0] cpu_write_data,
  output logic        cpu_write_ready,
  output logic        lcd_write_en,
  output logic [7:0]  lcd_write_data,
  output logic        ps2_overflow,
  output logic        busy
);

  localparam int unsigned AddrW = (PS2_FIFO_DEPTH > 1) ? $clog2(PS2_FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   cnt_q, cnt_d;
  logic [7:0]         fifo_q [PS2_FIFO_DEPTH];
  logic [AddrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               fifo_full, fifo_empty;
  logic               push, pop, drop;
  logic               grant_ps2, grant_cpu;

  logic unused_cpu_hi;
  assign unused_cpu_hi = ^cpu_write_data[31:8];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(PS2_FIFO_DEPTH));

`ifdef LCD_ARB_CPU_PRIO_EN
  always_comb begin
    grant_ps2 = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == StIdle) begin
      grant_cpu = cpu_write_en;
      grant_ps2 = !fifo_empty && !cpu_write_en;
    end
  end
`else
  // rr_last_q: 1 means the CPU won the most recent grant.
  logic rr_last_q;

  always_comb begin
    grant_ps2 = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == StIdle) begin
      grant_ps2 = !fifo_empty && (!cpu_write_en || rr_last_q);
      grant_cpu = cpu_write_en && !grant_ps2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last_q <= 1'b1;
    end else if (grant_ps2 || grant_cpu) begin
      rr_last_q <= grant_cpu;
    end
  end
`endif

  assign cpu_write_ready = grant_cpu;
  assign busy            = (state_q == StHold);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ps2 || grant_cpu) begin
          state_d = StHold;
          cnt_d   = HoldW'(HOLD_CYCLES - 1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign pop  = grant_ps2;
  assign push = ps2_key_pressed && (!fifo_full || pop);
  assign drop = ps2_key_pressed && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= ps2_key_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lcd_write_en   <= 1'b0;
      lcd_write_data <= 8'h00;
      ps2_overflow   <= 1'b0;
    end else begin
      lcd_write_en <= grant_ps2 || grant_cpu;
      if (grant_ps2) begin
        lcd_write_data <= fifo_q[rd_ptr_q];
      end else if (grant_cpu) begin
        lcd_write_data <= cpu_write_data[7:0];
      end
      if (drop) begin
        ps2_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_port_arbiter.sv
// Self-checking bench for lcd_port_arbiter: vector table plus hand-written multi-cycle sequences,
// with a scoreboard queue of expected LCD strobes checked by a monitor.
module tb_lcd_port_arbiter;

  localparam int unsigned Depth = 4;
  localparam int unsigned Hold  = 16;

  logic        clock;
  logic        reset;
  logic        ps2_key_pressed;
  logic [7:0]  ps2_key_data;
  logic        cpu_write_en;
  logic [31:0] cpu_write_data;
  logic        cpu_write_ready;
  logic        lcd_write_en;
  logic [7:0]  lcd_write_data;
  logic        ps2_overflow;
  logic        busy;

  lcd_port_arbiter #(
    .PS2_FIFO_DEPTH(Depth),
    .HOLD_CYCLES   (Hold)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data   (ps2_key_data),
    .cpu_write_en   (cpu_write_en),
    .cpu_write_data (cpu_write_data),
    .cpu_write_ready(cpu_write_ready),
    .lcd_write_en   (lcd_write_en),
    .lcd_write_data (lcd_write_data),
    .ps2_overflow   (ps2_overflow),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         cycle;   // absolute strobe cycle, -1 = unchecked
    int         gap;     // cycles since previous strobe, 0 = unchecked
    bit         is_cpu;
  } exp_t;

  typedef struct {
    bit          do_ps2;
    logic [7:0]  ps2_byte;
    bit          do_cpu;
    logic [31:0] cpu_word;
    int          n_exp;
    logic [7:0]  exp0;
    bit          exp0_cpu;
    logic [7:0]  exp1;
    int          exp_wait;
  } vec_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   hs_cyc = -100;
  int   last_strobe = -100;
  int   strobe_count = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cpu_write_en && cpu_write_ready) hs_cyc <= cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset && lcd_write_en) begin
      strobe_count++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got data %0h in cycle %0d, expected no strobe",
                 lcd_write_data, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_data", lcd_write_data, e.data);
        if (e.cycle >= 0) check("strobe_cycle", cyc, e.cycle);
        if (e.gap != 0) check("strobe_gap", cyc - last_strobe, e.gap);
        if (e.is_cpu) check("cpu_accept_to_strobe", cyc, hs_cyc + 1);
      end
      last_strobe = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_key_data = 8'h00;
    cpu_write_en = 1'b0;
    cpu_write_data = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic ps2_key(input logic [7:0] b);
    ps2_key_pressed = 1'b1;
    ps2_key_data = b;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] w, output int waited);
    cpu_write_data = w;
    cpu_write_en = 1'b1;
    waited = 0;
    forever begin
      #1;
      if (cpu_write_ready) break;
      @(negedge clock);
      waited++;
      if (waited > 200) begin
        total++;
        $display("FAIL cpu_ready_timeout: got no ready in 200 cycles, expected ready");
        break;
      end
    end
    @(posedge clock);
    @(negedge clock);
    cpu_write_en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    for (int i = 0; i < Hold + 4; i++) @(negedge clock);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  function automatic exp_t mk(input logic [7:0] d, input int c, input int g, input bit cpu);
    exp_t e;
    e.data = d; e.cycle = c; e.gap = g; e.is_cpu = cpu;
    return e;
  endfunction

  vec_t vecs[4];

  initial begin
    int c, waited, sc, first_busy, last_busy, busy_cnt;

    vecs[0] = '{1'b1, 8'h1C, 1'b0, 32'h0, 1, 8'h1C, 1'b0, 8'h00, -1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 32'hDEAD_BE41, 1, 8'h41, 1'b1, 8'h00, 0};
`ifdef LCD_ARB_CPU_PRIO_EN
    vecs[2] = '{1'b1, 8'h1C, 1'b1, 32'h0000_0041, 2, 8'h41, 1'b1, 8'h1C, 0};
    vecs[3] = '{1'b1, 8'hA5, 1'b1, 32'h1234_5678, 2, 8'h78, 1'b1, 8'hA5, 0};
`else
    vecs[2] = '{1'b1, 8'h1C, 1'b1, 32'h0000_0041, 2, 8'h1C, 1'b0, 8'h41, Hold + 1};
    vecs[3] = '{1'b1, 8'hA5, 1'b1, 32'h1234_5678, 2, 8'hA5, 1'b0, 8'h78, Hold + 1};
`endif

    // Reset state with all inputs low.
    do_reset();
    for (int i = 0; i < 5; i++) @(negedge clock);
    check("rst_lcd_write_en", lcd_write_en, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_write_ready", cpu_write_ready, 0);
    check("rst_ps2_overflow", ps2_overflow, 0);
    check("rst_lcd_write_data", lcd_write_data, 8'h00);

    // Table-driven single requests and ties straight out of reset.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      c = cyc;
      sb.push_back(mk(vecs[i].exp0, vecs[i].do_ps2 ? c + 2 : c + 1, 0, vecs[i].exp0_cpu));
      if (vecs[i].n_exp == 2) sb.push_back(mk(vecs[i].exp1, -1, Hold + 1, !vecs[i].exp0_cpu));
      if (vecs[i].do_ps2) ps2_key(vecs[i].ps2_byte);
      if (vecs[i].do_cpu) begin
        cpu_write(vecs[i].cpu_word, waited);
        if (vecs[i].exp_wait >= 0) check("vec_cpu_wait", waited, vecs[i].exp_wait);
      end
      drain("vec_drain");
    end

    // Busy window follows a single PS2 strobe.
    do_reset();
    c = cyc;
    sb.push_back(mk(8'h1C, c + 2, 0, 1'b0));
    ps2_key(8'h1C);
    first_busy = -1; last_busy = -1; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) begin
        if (first_busy < 0) first_busy = cyc;
        last_busy = cyc;
        busy_cnt++;
      end
      @(negedge clock);
    end
    check("busy_first_cycle", first_busy, c + 2);
    check("busy_last_cycle", last_busy, c + 1 + Hold);
    check("busy_count", busy_cnt, Hold);
    drain("busy_drain");

    // Round-robin after a PS2 grant: pending CPU beats a newly queued PS2 byte.
    do_reset();
    c = cyc;
    sb.push_back(mk(8'h2A, c + 2, 0, 1'b0));
    ps2_key(8'h2A);
    @(negedge clock);
    sb.push_back(mk(8'h44, -1, Hold + 1, 1'b1));
    sb.push_back(mk(8'h33, -1, Hold + 1, 1'b0));
    ps2_key(8'h33);
    cpu_write(32'h0000_0044, waited);
    drain("rr_drain");

    // Overflow: five keys while busy with a depth-4 FIFO.
    do_reset();
    sb.push_back(mk(8'h7F, -1, 0, 1'b1));
    for (int k = 1; k <= 4; k++) sb.push_back(mk(8'(k), -1, Hold + 1, 1'b0));
    cpu_write(32'h0000_007F, waited);
    check("ovf_busy_before_keys", busy, 1);
    for (int k = 1; k <= 4; k++) ps2_key(8'(k));
    check("ovf_not_yet", ps2_overflow, 0);
    ps2_key(8'h05);
    check("ovf_set", ps2_overflow, 1);
    drain("ovf_drain");
    check("ovf_sticky", ps2_overflow, 1);

    // Reset during HOLD with two bytes queued.
    do_reset();
    sb.push_back(mk(8'h5E, -1, 0, 1'b1));
    cpu_write(32'h0000_005E, waited);
    ps2_key(8'h11);
    ps2_key(8'h22);
    check("midrst_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy_after", busy, 0);
    check("midrst_lcd_write_data", lcd_write_data, 8'h00);
    sc = strobe_count;
    for (int i = 0; i < 40; i++) @(negedge clock);
    check("midrst_no_strobes", strobe_count, sc);
    check("midrst_sb_empty", sb.size(), 0);
    sb.delete();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lcd_port_arbiter.md
# lcd_port_arbiter

Shares the single character-LCD write port between two requesters: the PS2 keyboard interface and the processor's memory-mapped LCD write path. It buffers keyboard bytes in a small FIFO and arbitrates between them and processor writes. It issues one-cycle write strobes to the LCD controller, then enforces a hold-off window so the controller is never re-written while busy. It sits in the top level between `PS2_Interface`/`processor` and `lcd`.

## Interface
- `PS2_FIFO_DEPTH`, default 4: keyboard byte FIFO depth; power of two, ≥2.
- `HOLD_CYCLES`, default 16: busy window after each LCD write; ≥1.

- `clock`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- `ps2_key_pressed`  in  1  one-cycle strobe, new keyboard byte.
- `ps2_key_data`  in  8  keyboard byte, valid with strobe.
- `cpu_write_en`  in  1  processor write valid; held until accepted.
- `cpu_write_data`  in  32  processor write word; bits [7:0] used, [31:8] ignored.
- `cpu_write_ready`  out  1  combinational accept; transfer when `cpu_write_en & cpu_write_ready` at an edge.
- `lcd_write_en`  out  1  registered one-cycle write strobe to LCD controller.
- `lcd_write_data`  out  8  registered byte, valid while `lcd_write_en`=1; holds last value otherwise.
- `ps2_overflow`  out  1  sticky: a keyboard byte was dropped.
- `busy`  out  1  high while in HOLD.

## Operation
- FSM: IDLE, HOLD.
- IDLE: candidates are FIFO non-empty (PS2) and `cpu_write_en` (CPU).
  - One candidate: it is granted.
  - Both: round-robin. Grant the requester not recorded in `rr_last`.
- Grant edge:
  - `lcd_write_en`<=1, `lcd_write_data`<=granted byte.
  - PS2 grant pops FIFO; CPU grant completes the handshake.
  - `rr_last`<=granted, state<=HOLD, `cnt`<=HOLD_CYCLES-1.
- HOLD:
  - `lcd_write_en`<=0.
  - `cnt`==0 -> IDLE, else decrement.
- `cpu_write_ready` = IDLE & CPU granted. It is 0 in HOLD and 0 when PS2 wins the tie.
- FIFO push on `ps2_key_pressed`.
  - If full and no pop in the same cycle, the byte is dropped and `ps2_overflow`<=1.
  - Full with simultaneous pop: push accepted, count unchanged.
  - No bypass: a pushed byte is eligible for grant the following cycle at earliest.
- FIFO order preserved. Pointers wrap modulo PS2_FIFO_DEPTH. Count is 0..PS2_FIFO_DEPTH, held in clog2(DEPTH)+1 bits.
- Reset values:
  - state IDLE, FIFO empty, `rr_last`=CPU (PS2 wins the first tie).
  - `lcd_write_en`=0, `lcd_write_data`=8'h00, `ps2_overflow`=0.
  - `busy`=0, `cpu_write_ready`=0 when `cpu_write_en`=0.
- Reset mid-HOLD or with bytes queued:
  - HOLD abandoned and FIFO contents discarded.
  - No further strobes until new requests.

## Timing
- PS2 strobe in cycle N:
  - push at end of N, grant at end of N+1.
  - `lcd_write_en`=1 in cycle N+2.
- CPU valid in IDLE cycle M with no competitor:
  - `cpu_write_ready`=1 in M.
  - `lcd_write_en`=1 in M+1.
- `busy`=1 for exactly HOLD_CYCLES cycles, starting with the strobe cycle.
- Minimum spacing between consecutive `lcd_write_en` pulses: HOLD_CYCLES+1 cycles.
- Strobe and push in the same cycle as a reset: reset wins, byte discarded.

## Configuration
- `LCD_ARB_CPU_PRIO_EN` defined: fixed priority.
  - CPU always wins ties.
  - `rr_last` not implemented.
  - PS2 bytes accumulate and may overflow under sustained CPU writes.
- Undefined (default): round-robin as above.

## Test plan
- Reset, hold all inputs low for 5 cycles -> `lcd_write_en`=0, `busy`=0, `cpu_write_ready`=0, `ps2_overflow`=0, `lcd_write_data`=8'h00.
- `ps2_key_pressed` with 8'h1C in cycle 10 (default params) -> `lcd_write_en`=1 with 8'h1C in cycle 12 only; `busy`=1 cycles 12–27, 0 in cycle 28.
- After reset, PS2 byte 8'h1C queued and `cpu_write_en`=1 with 32'h0000_0041 in the same IDLE cycle -> 8'h1C strobed first, 8'h41 strobed 17 cycles later; `cpu_write_ready` high only in the cycle before the second strobe.
- Depth 4, 5 distinct PS2 strobes 8'h01..8'h05 while `busy` -> `ps2_overflow`=1; exactly 8'h01..8'h04 emitted in order, 17 cycles apart.
- With `LCD_ARB_CPU_PRIO_EN`, same tie as scenario 3 -> 8'h41 strobed first, then 8'h1C.
- Assert `reset` for 1 cycle in HOLD with 2 bytes queued -> `busy`=0 the next cycle, no `lcd_write_en` for 40 cycles with no new requests.
